// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared types and helpers for the serial adder/subtractor
package add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int iter_count(input int width, input int slice);
    return width / slice;
  endfunction

endpackage

// File: rtl/add_sub_serial_ls83.sv
// rtl/add_sub_serial_ls83.sv - LS83-style ripple adder slice (a + b + cin)
module add_sub_serial_ls83 #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/add_sub_serial.sv
// rtl/add_sub_serial.sv - multi-cycle adder/subtractor iterating one adder slice
module add_sub_serial
  import add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = iter_count(WIDTH, SLICE);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  generate
    if (WIDTH % SLICE != 0) begin : g_bad_width
      $fatal(1, "add_sub_serial: WIDTH must be a multiple of SLICE");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [SLICE-1:0] slice_a, slice_b, slice_sum;
  logic             slice_cout;

  assign slice_a = opa_q[int'(cnt_q)*SLICE +: SLICE];
  assign slice_b = opb_q[int'(cnt_q)*SLICE +: SLICE];

  // opb is already inverted for subtraction, so the slice only ever adds
  add_sub_serial_ls83 #(.W(SLICE)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = b ^ {WIDTH{mode == MODE_SUB}};
          carry_d = mode;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[int'(cnt_q)*SLICE +: SLICE] = slice_sum;
        carry_d = slice_cout;
        if (cnt_q == CNT_LAST) begin
          // flags latched from the final slice so they stay stable through DONE
          cout_d  = slice_cout;
          ovf_d   = (opa_q[WIDTH-1] == opb_q[WIDTH-1]) &&
                    (slice_sum[SLICE-1] != opa_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_add_sub_serial.sv
// tb/tb_add_sub_serial.sv - directed and random checks of add_sub_serial
module tb_add_sub_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        mode;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  add_sub_serial #(.WIDTH(16), .SLICE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: {overflow, carry_out, sum}
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic m);
    logic [15:0] yi;
    logic [16:0] r;
    logic        v;
    yi = y ^ {16{m}};
    r  = {1'b0, x} + {1'b0, yi} + {16'd0, m};
    v  = (x[15] == yi[15]) && (r[15] != x[15]);
    return {v, r};
  endfunction

  // called just after an edge with the DUT idle; returns just after the accept edge
  task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic m);
    a = x; b = y; mode = m; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); mode = 1'($urandom);
  endtask

  task automatic wait_done(input string tag, input logic chk_lat);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (chk_lat) check_eq({tag, "_latency"}, lat, 4);
  endtask

  task automatic finish_op(input string tag, input logic [15:0] es, input logic ec, input logic ev);
    check_eq({tag, "_sum"}, 32'(sum), 32'(es));
    check_eq({tag, "_cout"}, 32'(carry_out), 32'(ec));
    check_eq({tag, "_ovf"}, 32'(overflow), 32'(ev));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq({tag, "_idle"}, 32'(in_ready), 32'd1);
  endtask

  logic [15:0] va [6] = '{16'h1234, 16'h0005, 16'h0003, 16'h7FFF, 16'hFFFF, 16'h8000};
  logic [15:0] vb [6] = '{16'h1111, 16'h0003, 16'h0005, 16'h0001, 16'h0001, 16'h0001};
  logic        vm [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [15:0] vs [6] = '{16'h2345, 16'h0002, 16'hFFFE, 16'h8000, 16'h0000, 16'h7FFF};
  logic        vc [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic        vv [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    logic [17:0] exp;
    logic [15:0] ra, rb;
    logic        rm;
    int          guard;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; mode = 1'b0; out_ready = 1'b0;
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_flags", {30'd0, carry_out, overflow}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start_op(va[i], vb[i], vm[i]);
      wait_done($sformatf("vec%0d", i), 1'b1);
      finish_op($sformatf("vec%0d", i), vs[i], vc[i], vv[i]);
    end

    // backpressure: result must hold while a competing request waits
    start_op(16'h1234, 16'h1111, 1'b0);
    wait_done("bp", 1'b1);
    a = 16'hAAAA; b = 16'h5555; mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("bp_hold_sum", 32'(sum), 32'h2345);
      check_eq("bp_hold_valid", 32'(out_valid), 32'd1);
      check_eq("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_eq("bp_next_accept", 32'(in_ready), 32'd0);
    wait_done("bp_next", 1'b1);
    finish_op("bp_next", 16'hFFFF, 1'b0, 1'b0);

    // asynchronous reset after the second slice
    start_op(16'h7FFF, 16'h7FFF, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_sum", 32'(sum), 32'd0);
    check_eq("mid_rst_flags", {30'd0, carry_out, overflow}, 32'd0);
    #1;
    rst = 1'b0;
    start_op(16'h00FF, 16'h0001, 1'b0);
    wait_done("post_rst", 1'b1);
    finish_op("post_rst", 16'h0100, 1'b0, 1'b0);

    // random ops with out_ready toggled at random, including before DONE
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom);
      exp = model(ra, rb, rm);
      start_op(ra, rb, rm);
      guard = 0;
      while (!out_valid && guard < 20) begin
        out_ready = 1'($urandom);
        @(posedge clk); #1;
        guard++;
      end
      out_ready = 1'b0;
      check_eq("rnd_valid", 32'(out_valid), 32'd1);
      guard = 0;
      while ($urandom_range(0, 2) != 0 && guard < 5) begin
        @(posedge clk); #1;
        guard++;
      end
      finish_op("rnd", exp[15:0], exp[16], exp[17]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/add_sub_serial.md
# add_sub_serial

Multi-cycle adder/subtractor that computes the same 16-bit result as our parallel four-slice adder/subtractor. It uses a single 4-bit adder slice, iterated over the operand one nibble per clock. It sits on area-constrained datapaths and trades latency for logic. Operands enter and results leave through valid/ready handshakes, so the block can sit between pipeline stages with backpressure.

## Interface
- WIDTH, 16, operand/result width; must be an integer multiple of SLICE.
- SLICE, 4, bits processed per cycle. N = WIDTH/SLICE iterations.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and mode are valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  first operand.
- b  in  WIDTH  second operand.
- mode  in  1  0 = a+b, 1 = a−b (two's complement).
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  result, modulo 2^WIDTH.
- carry_out  out  1  carry out of the MSB. For subtraction, 1 means no borrow (a ≥ b unsigned).
- overflow  out  1  signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- in_ready = (state == IDLE), a combinational decode. out_valid = (state == DONE).
- **IDLE:** on in_valid && in_ready:
  - latch opa = a and opb = b ^ {WIDTH{mode}};
  - set carry register = mode and cnt = 0;
  - go to RUN.
- **RUN:** each cycle, add slice cnt of opa, slice cnt of opb, and the carry register in the 4-bit slice.
  - Store the slice sum into sum bits [cnt*SLICE +: SLICE]. Update carry from the slice cout.
  - When cnt == N−1, go to DONE; otherwise cnt increments.
- **DONE:** hold sum, carry_out and overflow stable. On out_ready, go to IDLE.
- **Flags:**
  - carry_out is the final carry register.
  - overflow = (opa[MSB] == opb[MSB]) && (sum[MSB] != opa[MSB]), where opb is the inverted operand.
- **Input handling:**
  - Inputs a, b and mode are sampled only on the accept edge. Changes during RUN or DONE have no effect.
  - in_valid asserted while in_ready = 0 is ignored. The upstream holds it.
- **Reset (async, any state including mid-RUN):**
  - state = IDLE, cnt = 0, sum = 0, carry_out = 0, overflow = 0, out_valid = 0;
  - in_ready = 1 immediately;
  - the partial result is discarded.

## Timing
- Accept at edge k → slices processed on edges k+1..k+N → out_valid high from edge k+N (N = 4 by default).
- out_valid stays high until the first edge where out_ready = 1. State is IDLE one cycle later.
- Minimum issue interval is N+2 cycles: accept, N RUN cycles, one DONE cycle with out_ready = 1.
- Acceptance in DONE is not supported; in_ready is low there.
- out_ready is sampled only in DONE. out_ready asserted early has no effect.
- Outputs are registered (except in_ready and out_valid, which are state decodes). No combinational path from the inputs to sum, carry_out or overflow.

## Structure
- Package add_sub_pkg:
  - state enum (IDLE, RUN, DONE);
  - localparams MODE_ADD = 1'b0 and MODE_SUB = 1'b1;
  - a function computing N from WIDTH and SLICE.
- Elaboration check: WIDTH % SLICE == 0, else fatal.
- One sub-module instance: the existing LS83 4-bit adder slice (a, b, cin, sum, cout), instanced once. Its b input is driven from the pre-inverted opb slice.
- Counter width: $clog2(N), minimum 1.

## Test plan
- **Add:** a = 0x1234, b = 0x1111, mode = 0 → sum = 0x2345, carry_out = 0, overflow = 0. out_valid exactly 4 cycles after the accept edge.
- **Subtract, no borrow:** a = 0x0005, b = 0x0003, mode = 1 → sum = 0x0002, carry_out = 1, overflow = 0.
- **Subtract with borrow:** a = 0x0003, b = 0x0005, mode = 1 → sum = 0xFFFE, carry_out = 0, overflow = 0.
- **Add boundaries:**
  - a = 0x7FFF, b = 0x0001, mode = 0 → sum = 0x8000, overflow = 1, carry_out = 0.
  - a = 0xFFFF, b = 0x0001 → sum = 0x0000, carry_out = 1, overflow = 0.
  - a = 0x8000, b = 0x0001, mode = 1 → sum = 0x7FFF, overflow = 1, carry_out = 1.
- **Backpressure:** hold out_ready = 0 for 10 cycles in DONE → outputs stable, in_ready = 0, a new in_valid is not accepted. Release out_ready → in_ready = 1 next cycle, and a back-to-back op is accepted.
- **Reset mid-RUN:** assert rst after the 2nd slice → in_ready = 1 and all outputs 0 with no clock edge required. A following op 0x00FF + 0x0001 → 0x0100 correct. Finish with 1000 random ops (mixed mode, random out_ready) checked against a reference model.
